coprocessador: RTL

COPROCESSADOR -- requirements
Module: coprocessador

---
 rtl/coprocessador.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/coprocessador.sv
// 5x5 signed 8-bit matrix coprocessor: ADD, SUB, MUL, TRANSP, OPOSTO, ESCALAR.
// Operands are snapshotted in CARGA; results stay in 9-bit registers and are held while pronto is high.
module coprocessador (
    input  logic         clk,
    input  logic         reset,
    input  logic         iniciar,
    input  logic [2:0]   opcode,
    input  logic [199:0] matriz_A,
    input  logic [199:0] matriz_B,
    output logic [224:0] matriz_C,
    output logic         pronto
);

    typedef enum logic [1:0] {IDLE, CARGA, CALC, FIM} state_t;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_MUL     = 3'b010;
    localparam logic [2:0] OP_TRANSP  = 3'b011;
    localparam logic [2:0] OP_OPOSTO  = 3'b100;
    localparam logic [2:0] OP_ESCALAR = 3'b101;

    state_t        state_reg, state_next;
    logic [199:0]  a_reg, b_reg;
    logic [2:0]    op_reg;
    logic [2:0]    row_reg, col_reg, t_reg;
    logic [19:0]   acc_reg;
    logic          pronto_reg;
    logic [8:0]    c_mem [25];

    logic signed [7:0] a_el [25];
    logic signed [7:0] b_el [25];

    genvar gi;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_elem
            assign a_el[gi]              = a_reg[gi*8 +: 8];
            assign b_el[gi]              = b_reg[gi*8 +: 8];
            assign matriz_C[gi*9 +: 9]   = c_mem[gi];
        end
    endgenerate

    assign pronto = pronto_reg;

    function automatic logic [4:0] idx5(input logic [2:0] r, input logic [2:0] c);
        return 5'({2'b00, r} * 5'd5 + {2'b00, c});
    endfunction

    logic [4:0]        elem_idx, tr_idx, mul_a_idx, mul_b_idx;
    logic signed [7:0] a_cur, b_cur, a_tr, s_el, a_mul, b_mul;
    logic signed [15:0] prod_s, prod_m;
    logic [19:0]       mac_sum;
    logic [8:0]        res;
    logic              calc_done;

    always_comb begin
        elem_idx  = idx5(row_reg, col_reg);
        tr_idx    = idx5(col_reg, row_reg);
        mul_a_idx = idx5(row_reg, t_reg);
        mul_b_idx = idx5(t_reg, col_reg);
        a_cur     = a_el[elem_idx];
        b_cur     = b_el[elem_idx];
        a_tr      = a_el[tr_idx];
        s_el      = b_el[0];
        a_mul     = a_el[mul_a_idx];
        b_mul     = b_el[mul_b_idx];
        prod_s    = a_cur * s_el;
        prod_m    = a_mul * b_mul;
        mac_sum   = acc_reg + {{4{prod_m[15]}}, prod_m};
        res       = 9'd0;
        case (op_reg)
            OP_ADD:     res = {a_cur[7], a_cur} + {b_cur[7], b_cur};
            OP_SUB:     res = {a_cur[7], a_cur} - {b_cur[7], b_cur};
            OP_MUL:     res = mac_sum[8:0];
            OP_TRANSP:  res = {a_tr[7], a_tr};
            OP_OPOSTO:  res = 9'd0 - {a_cur[7], a_cur};
            OP_ESCALAR: res = prod_s[8:0];
            default:    res = 9'd0;
        endcase
        // MUL only finishes an element on its fifth term
        calc_done = (row_reg == 3'd4) && (col_reg == 3'd4) &&
                    ((op_reg != OP_MUL) || (t_reg == 3'd4));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (iniciar) state_next = CARGA;
            CARGA: state_next = (opcode[2:1] == 2'b11) ? FIM : CALC;
            CALC:  if (calc_done) state_next = FIM;
            // first FIM cycle raises pronto; exit only after it has been shown
            FIM:   if (!iniciar && pronto_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            row_reg    <= '0;
            col_reg    <= '0;
            t_reg      <= '0;
            acc_reg    <= '0;
            pronto_reg <= 1'b0;
            for (int i = 0; i < 25; i++) c_mem[i] <= '0;
        end else begin
            pronto_reg <= (state_reg == FIM) && (state_next == FIM);
            case (state_reg)
                CARGA: begin
                    a_reg   <= matriz_A;
                    b_reg   <= matriz_B;
                    op_reg  <= opcode;
                    row_reg <= '0;
                    col_reg <= '0;
                    t_reg   <= '0;
                    acc_reg <= '0;
                    for (int i = 0; i < 25; i++) c_mem[i] <= '0;
                end
                CALC: begin
                    if (op_reg == OP_MUL && t_reg != 3'd4) begin
                        acc_reg <= mac_sum;
                        t_reg   <= t_reg + 3'd1;
                    end else begin
                        c_mem[elem_idx] <= res;
                        acc_reg <= '0;
                        t_reg   <= '0;
                        if (col_reg == 3'd4) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 3'd1;
                        end else begin
                            col_reg <= col_reg + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
